// File: rtl/lcd_key_writer_if.sv
// Bundles the keypad-side key strobe and the board-side LCD pins of
// lcd_key_writer into a single interface.
//   key_value  4  key code, valid while key_down=1
//   key_down   1  one-cycle key strobe from the keypad scanner
//   LCD_DATA   8  LCD DB7..DB0
//   LCD_RS     1  0=command, 1=data
//   LCD_RW     1  always 0 (write only)
//   LCD_E      1  LCD enable strobe
//   LCD_ON     1  LCD power enable
//   ready      1  writer idle with an empty key buffer
//   overrun    1  sticky key-dropped flag
// Modports: master = keypad/system side (drives keys, observes LCD pins
// and status); slave = the lcd_key_writer itself.
interface lcd_key_writer_if;
  logic [3:0] key_value;
  logic       key_down;
  logic [7:0] LCD_DATA;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_E;
  logic       LCD_ON;
  logic       ready;
  logic       overrun;

  modport master (
    output key_value, key_down,
    input  LCD_DATA, LCD_RS, LCD_RW, LCD_E, LCD_ON, ready, overrun
  );

  modport slave (
    input  key_value, key_down,
    output LCD_DATA, LCD_RS, LCD_RW, LCD_E, LCD_ON, ready, overrun
  );
endinterface

// File: rtl/lcd_key_writer.sv
// lcd_key_writer: receives 4-bit keypad codes, maps them to ASCII and writes
// them to a 16x2 HD44780 LCD over its 8-bit write-only bus. Runs the LCD
// power-up init (0x38, 0x0C, 0x06, 0x01), tracks the cursor over both lines
// and inserts a DDRAM address command when a line fills up.
// Ports:
//   CLOCK_50  in  system clock
//   reset     in  asynchronous, active-low reset
//   bus       lcd_key_writer_if.slave: key_value/key_down in; LCD_DATA,
//             LCD_RS, LCD_RW, LCD_E, LCD_ON, ready, overrun out
// Optional feature macro: LCD_KEY_CLEAR_EN
//   defined   -> key code 12 clears the display (0x01) instead of printing '*'
//   undefined -> key code 12 prints '*' like any other key
module lcd_key_writer #(
  parameter int unsigned PWRUP_CYC    = 1000000,
  parameter int unsigned E_PULSE_CYC  = 25,
  parameter int unsigned CMD_WAIT_CYC = 2500,
  parameter int unsigned CLR_WAIT_CYC = 100000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  lcd_key_writer_if.slave   bus
);

  typedef enum logic [2:0] {
    PWR_WAIT, INIT, IDLE, SETUP, E_HIGH, HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  init_idx_q, init_idx_d;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d;
  logic        e_q, e_d;
  logic        on_q;
  logic [3:0]  buf_q, buf_d;
  logic        full_q, full_d;
  logic        ovr_q, ovr_d;
  logic [3:0]  col_q, col_d;
  logic        line_q, line_d;
  logic        pend_q, pend_d;
  logic [7:0]  pend_byte_q, pend_byte_d;
  logic        pop;

  function automatic logic [7:0] key_ascii(input logic [3:0] k);
    case (k)
      4'd0:    key_ascii = 8'h31; // '1'
      4'd1:    key_ascii = 8'h32; // '2'
      4'd2:    key_ascii = 8'h33; // '3'
      4'd3:    key_ascii = 8'h2B; // '+'
      4'd4:    key_ascii = 8'h34; // '4'
      4'd5:    key_ascii = 8'h35; // '5'
      4'd6:    key_ascii = 8'h36; // '6'
      4'd7:    key_ascii = 8'h2D; // '-'
      4'd8:    key_ascii = 8'h37; // '7'
      4'd9:    key_ascii = 8'h38; // '8'
      4'd10:   key_ascii = 8'h39; // '9'
      4'd11:   key_ascii = 8'h78; // 'x'
      4'd12:   key_ascii = 8'h2A; // '*'
      4'd13:   key_ascii = 8'h30; // '0'
      4'd14:   key_ascii = 8'h3D; // '='
      default: key_ascii = 8'h2F; // '/'
    endcase
  endfunction

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    init_byte = 8'h38; // 8-bit bus, 2 lines, 5x8 font
      3'd1:    init_byte = 8'h0C; // display on, cursor off
      3'd2:    init_byte = 8'h06; // increment, no shift
      default: init_byte = 8'h01; // clear
    endcase
  endfunction

  // The buffered key leaves the one-entry buffer when IDLE starts its write.
  assign pop = (state_q == IDLE) && full_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_idx_d  = init_idx_q;
    data_d      = data_q;
    rs_d        = rs_q;
    col_d       = col_q;
    line_d      = line_q;
    pend_d      = pend_q;
    pend_byte_d = pend_byte_q;

    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == 32'd0) state_d = INIT;
        else                cnt_d   = cnt_q - 32'd1;
      end
      INIT: begin
        // Only entered with commands still outstanding.
        data_d     = init_byte(init_idx_q);
        rs_d       = 1'b0;
        init_idx_d = init_idx_q + 3'd1;
        cnt_d      = E_PULSE_CYC - 32'd1;
        state_d    = SETUP;
      end
      IDLE: begin
        if (full_q) begin
          state_d = SETUP;
          cnt_d   = E_PULSE_CYC - 32'd1;
`ifdef LCD_KEY_CLEAR_EN
          if (buf_q == 4'd12) begin
            data_d = 8'h01;
            rs_d   = 1'b0;
            col_d  = 4'd0;
            line_d = 1'b0;
          end else
`endif
          begin
            data_d = key_ascii(buf_q);
            rs_d   = 1'b1;
            if (col_q == 4'd15) begin
              // Last column: queue the address command that moves the
              // cursor to the start of the other line as part of this job.
              col_d       = 4'd0;
              line_d      = ~line_q;
              pend_d      = 1'b1;
              pend_byte_d = line_q ? 8'h80 : 8'hC0;
            end else begin
              col_d = col_q + 4'd1;
            end
          end
        end
      end
      SETUP: begin
        if (cnt_q == 32'd0) begin
          state_d = E_HIGH;
          cnt_d   = E_PULSE_CYC - 32'd1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      E_HIGH: begin
        if (cnt_q == 32'd0) begin
          state_d = HOLD;
          // Clear display needs the long execution wait.
          cnt_d   = (!rs_q && data_q == 8'h01) ? CLR_WAIT_CYC - 32'd1
                                               : CMD_WAIT_CYC - 32'd1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 32'd0) begin
          if (pend_q) begin
            data_d  = pend_byte_q;
            rs_d    = 1'b0;
            pend_d  = 1'b0;
            cnt_d   = E_PULSE_CYC - 32'd1;
            state_d = SETUP;
          end else if (init_idx_q != 3'd4) begin
            state_d = INIT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = PWR_WAIT;
    endcase
  end

  // Key buffer: a pop frees the entry in the same cycle, so a simultaneous
  // key_down is captured rather than counted as an overrun.
  always_comb begin
    full_d = full_q & ~pop;
    buf_d  = buf_q;
    ovr_d  = ovr_q;
    if (bus.key_down) begin
      if (!full_d) begin
        full_d = 1'b1;
        buf_d  = bus.key_value;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // Registered E so the strobe is glitch-free and drops on reset at once.
  assign e_d = (state_d == E_HIGH);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= PWRUP_CYC - 32'd1;
      init_idx_q  <= 3'd0;
      data_q      <= 8'h00;
      rs_q        <= 1'b0;
      e_q         <= 1'b0;
      on_q        <= 1'b0;
      buf_q       <= 4'd0;
      full_q      <= 1'b0;
      ovr_q       <= 1'b0;
      col_q       <= 4'd0;
      line_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_byte_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_idx_q  <= init_idx_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      e_q         <= e_d;
      on_q        <= 1'b1;
      buf_q       <= buf_d;
      full_q      <= full_d;
      ovr_q       <= ovr_d;
      col_q       <= col_d;
      line_q      <= line_d;
      pend_q      <= pend_d;
      pend_byte_q <= pend_byte_d;
    end
  end

  assign bus.LCD_DATA = data_q;
  assign bus.LCD_RS   = rs_q;
  assign bus.LCD_RW   = 1'b0;
  assign bus.LCD_E    = e_q;
  assign bus.LCD_ON   = on_q;
  assign bus.ready    = (state_q == IDLE) && !full_q;
  assign bus.overrun  = ovr_q;

endmodule

// File: tb/tb_lcd_key_writer.sv
// Bench for lcd_key_writer with shortened timing. Stimulus pushes the
// expected {RS,DATA} of every LCD write into a queue; a monitor pops and
// compares on each rising LCD_E and checks the E pulse width.
module tb_lcd_key_writer;
  localparam int unsigned PWRUP = 100;
  localparam int unsigned EP    = 2;
  localparam int unsigned CMDW  = 10;
  localparam int unsigned CLRW  = 40;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  lcd_key_writer_if bus();

  lcd_key_writer #(
    .PWRUP_CYC(PWRUP), .E_PULSE_CYC(EP),
    .CMD_WAIT_CYC(CMDW), .CLR_WAIT_CYC(CLRW)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  logic e_prev = 1'b0;
  int   e_width = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compares each LCD write against the scoreboard.
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      e_prev  = 1'b0;
      e_width = 0;
    end else begin
      if (bus.LCD_E && !e_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got rs=%0d data=0x%02h, expected no write",
                   bus.LCD_RS, bus.LCD_DATA);
        end else begin
          logic [8:0] exp;
          exp = exp_q.pop_front();
          $display("write rs=%0d data=0x%02h (expected rs=%0d data=0x%02h)",
                   bus.LCD_RS, bus.LCD_DATA, exp[8], exp[7:0]);
          check("lcd_write", 32'({bus.LCD_RS, bus.LCD_DATA}), 32'(exp));
        end
      end
      if (bus.LCD_E) e_width++;
      else if (e_prev) begin
        check("e_width", 32'(e_width), 32'(EP));
        e_width = 0;
      end
      e_prev = bus.LCD_E;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic pulse_key(input logic [3:0] code);
    bus.key_value = code;
    bus.key_down  = 1'b1;
    @(negedge CLOCK_50);
    bus.key_down  = 1'b0;
  endtask

  task automatic send(input logic [3:0] code, input logic rs, input logic [7:0] data);
    exp_q.push_back({rs, data});
    pulse_key(code);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (!(bus.ready && exp_q.size() == 0) && n < bound) begin
      @(negedge CLOCK_50);
      n++;
    end
    check(name, 32'(bus.ready && exp_q.size() == 0), 32'd1);
  endtask

  task automatic wait_e_high(input string name, input int bound);
    int n = 0;
    while (!bus.LCD_E && n < bound) begin
      @(negedge CLOCK_50);
      n++;
    end
    check(name, 32'(bus.LCD_E), 32'd1);
  endtask

  task automatic push_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006);
    exp_q.push_back(9'h001);
  endtask

  initial begin
    int n;
    bus.key_value = 4'd0;
    bus.key_down  = 1'b0;
    tick(3);

    // Reset state
    check("rst_data",    32'(bus.LCD_DATA), 32'd0);
    check("rst_rs",      32'(bus.LCD_RS),   32'd0);
    check("rst_rw",      32'(bus.LCD_RW),   32'd0);
    check("rst_e",       32'(bus.LCD_E),    32'd0);
    check("rst_on",      32'(bus.LCD_ON),   32'd0);
    check("rst_ready",   32'(bus.ready),    32'd0);
    check("rst_overrun", 32'(bus.overrun),  32'd0);

    // Init sequence
    push_init();
    reset = 1'b1;
    tick(1);
    check("lcd_on", 32'(bus.LCD_ON), 32'd1);
    check("ready_pwrup", 32'(bus.ready), 32'd0);
    wait_idle("init_done", 400);

    // Fill both lines with '5': address commands after the 16th and 32nd
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(9'h135);
      if (i == 15) exp_q.push_back(9'h0C0);
      if (i == 31) exp_q.push_back(9'h080);
      pulse_key(4'd5);
      wait_idle("row_fill", 100);
    end

    // Key 13 -> '0', ready low until HOLD ends (16 edges after the strobe)
    exp_q.push_back(9'h130);
    pulse_key(4'd13);
    check("ready_busy", 32'(bus.ready), 32'd0);
    n = 1;
    while (!bus.ready && n < 100) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("key_latency", 32'(n), 32'd16);
    check("key_queue_empty", 32'(exp_q.size()), 32'd0);

    // Code 12
`ifdef LCD_KEY_CLEAR_EN
    exp_q.push_back(9'h001);
    pulse_key(4'd12);
    wait_idle("clear_done", 200);
`else
    send(4'd12, 1'b1, 8'h2A);
    wait_idle("star_done", 100);
`endif

    // Overrun: second key during the transfer is kept, third is dropped
    check("ovr_before", 32'(bus.overrun), 32'd0);
    send(4'd0, 1'b1, 8'h31);
    wait_e_high("ovr_e_high", 50);
    send(4'd1, 1'b1, 8'h32);
    pulse_key(4'd2);
    check("ovr_set", 32'(bus.overrun), 32'd1);
    wait_idle("ovr_done", 100);

    // Reset during E high
    send(4'd3, 1'b1, 8'h2B);
    wait_e_high("rst_e_high", 50);
    #3;
    check("queue_at_reset", 32'(exp_q.size()), 32'd0);
    reset = 1'b0;
    #1;
    check("abort_e",       32'(bus.LCD_E),   32'd0);
    check("abort_overrun", 32'(bus.overrun), 32'd0);
    check("abort_ready",   32'(bus.ready),   32'd0);
    exp_q.delete();
    tick(2);
    push_init();
    reset = 1'b1;
    wait_idle("reinit_done", 400);
    send(4'd6, 1'b1, 8'h36);
    wait_idle("post_reinit", 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
